// File: rtl/cdb_pkg.sv
// Shared types and widths for the common-data-bus arbiter slice.
// Tag 0 is the idle/null tag and is never broadcast as a real result.
package cdb_pkg;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int CDB_W  = TAG_W + DATA_W;

    localparam logic [TAG_W-1:0] NULL_TAG = '0;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

    function automatic cdb_t cdb_pack(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        cdb_t e;
        e.tag  = tag;
        e.data = data;
        return e;
    endfunction

    function automatic logic cdb_is_null(input cdb_t e);
        return e.tag == NULL_TAG;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-request and CDB broadcast bundle between execution units and the arbiter.
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_CDB = 3
) ();

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*CDB_W-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_CDB*CDB_W-1:0] cdb;
    logic [NUM_CDB-1:0]       cdb_valid;

    modport master (
        output req_valid, req_data,
        input  req_ready, cdb, cdb_valid
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, cdb, cdb_valid
    );

endinterface

// File: rtl/cdb_req_fifo.sv
// Two-entry per-unit result queue; ready comes from the registered count only.
module cdb_req_fifo
    import cdb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  cdb_t       din,
    input  logic       pop,
    output cdb_t       dout,
    output logic [1:0] count,
    output logic       ready
);

    cdb_t mem [2];
    logic wr_ptr;
    logic rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign ready = (count != 2'd2);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to NUM_CDB queued results per cycle onto registered CDB slots.
// Optional performance counters are built when CDB_ARBITER_PERF_EN is defined.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_CDB = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic kill,
    cdb_arbiter_if.slave bus
`ifdef CDB_ARBITER_PERF_EN
    ,
    output logic [31:0] perf_grant_cnt,
    output logic [31:0] perf_conflict_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    cdb_t               head [NUM_REQ];
    logic [NUM_REQ-1:0] non_empty;
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] grant;

    cdb_t               slot_ent [NUM_CDB];
    logic [NUM_CDB-1:0] slot_vld;
    cdb_t               cdb_q [NUM_CDB];
    logic [NUM_CDB-1:0] cdb_valid_q;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    logic [PTR_W-1:0]   last_idx;

    // Null-tag pushes are handshaken but never enter the queue.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        cdb_t       req_ent;
        logic [1:0] count;

        assign req_ent      = bus.req_data[i*CDB_W +: CDB_W];
        assign push[i]      = bus.req_valid[i] & ready[i] & ~cdb_is_null(req_ent);
        assign non_empty[i] = (count != 2'd0);

        cdb_req_fifo u_fifo (
            .clk   (clk),
            .rst_n (reset_n),
            .flush (kill),
            .push  (push[i]),
            .din   (req_ent),
            .pop   (grant[i]),
            .dout  (head[i]),
            .count (count),
            .ready (ready[i])
        );
    end

    assign bus.req_ready = ready;

    always_comb begin : arb
        int idx;
        int n;
        grant    = '0;
        slot_vld = '0;
        last_idx = rr_ptr;
        idx      = 0;
        n        = 0;
        for (int k = 0; k < NUM_CDB; k++) begin
            slot_ent[k] = '0;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = int'(rr_ptr) + j;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (non_empty[idx] && (n < NUM_CDB)) begin
                grant[idx]  = 1'b1;
                slot_vld[n] = 1'b1;
                slot_ent[n] = head[idx];
                last_idx    = PTR_W'(idx);
                n           = n + 1;
            end
        end
    end

    always_comb begin
        rr_next = rr_ptr;
        if (|grant) begin
            rr_next = (int'(last_idx) == NUM_REQ - 1) ? '0 : last_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr      <= '0;
            cdb_valid_q <= '0;
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_q[k] <= '0;
            end
        end else if (kill) begin
            rr_ptr      <= '0;
            cdb_valid_q <= '0;
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_q[k] <= '0;
            end
        end else begin
            rr_ptr      <= rr_next;
            cdb_valid_q <= slot_vld;
            cdb_q       <= slot_ent;
        end
    end

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_slot
        assign bus.cdb[k*CDB_W +: CDB_W] = cdb_q[k];
    end
    assign bus.cdb_valid = cdb_valid_q;

`ifdef CDB_ARBITER_PERF_EN
    logic [31:0] grant_inc;
    logic        conflict;

    assign grant_inc = 32'($countones(grant));
    assign conflict  = ($countones(non_empty) > NUM_CDB);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_grant_cnt    <= '0;
            perf_conflict_cnt <= '0;
        end else if (kill) begin
            perf_grant_cnt    <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (perf_grant_cnt > (32'hFFFF_FFFF - grant_inc)) begin
                perf_grant_cnt <= 32'hFFFF_FFFF;
            end else begin
                perf_grant_cnt <= perf_grant_cnt + grant_inc;
            end
            if (conflict && (perf_conflict_cnt != 32'hFFFF_FFFF)) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (4 units, 3 buses) with a per-unit ordering scoreboard.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NR = 4;
    localparam int NC = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic kill;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_REQ(NR), .NUM_CDB(NC)) bus ();

`ifdef CDB_ARBITER_PERF_EN
    logic [31:0] perf_grant_cnt;
    logic [31:0] perf_conflict_cnt;
`endif

    cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(NC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kill    (kill),
        .bus     (bus)
`ifdef CDB_ARBITER_PERF_EN
        ,
        .perf_grant_cnt    (perf_grant_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   pcnt [NR];
    int   gcnt [NR];
    int   sb_wr [NR];
    int   sb_rd [NR];
    cdb_t sb_mem [NR][64];
    bit   sb_en;
    int   k0, k1, k2, k3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Unit u's k-th pushed result: unit id sits in tag[5:3] and data[17:16].
    function automatic cdb_t exp_word(input int u, input int k);
        return cdb_pack(TAG_W'(8 * u + (k % 7) + 1), 32'hA000_0000 | (32'(u) << 16) | 32'(k));
    endfunction

    function automatic cdb_t slot(input int k);
        logic [NC*CDB_W-1:0] v;
        v = bus.cdb;
        return v[k*CDB_W +: CDB_W];
    endfunction

    task automatic drive_data();
        for (int u = 0; u < NR; u++) begin
            bus.req_data[u*CDB_W +: CDB_W] = exp_word(u, pcnt[u]);
        end
    endtask

    task automatic tick();
        logic [NR-1:0] v_pre;
        logic [NR-1:0] r_pre;
        logic          k_pre;
        cdb_t          d_pre [NR];
        cdb_t          e;
        int            u;
        v_pre = bus.req_valid;
        r_pre = bus.req_ready;
        k_pre = kill;
        for (int i = 0; i < NR; i++) begin
            d_pre[i] = bus.req_data[i*CDB_W +: CDB_W];
        end
        @(posedge clk);
        #1;
        if (sb_en) begin
            for (int k = 0; k < NC; k++) begin
                if (bus.cdb_valid[k]) begin
                    e = slot(k);
                    u = int'(e.data[17:16]);
                    gcnt[u]++;
                    if (sb_rd[u] == sb_wr[u]) begin
                        check($sformatf("sb_unexpected_u%0d", u), 64'(e), 64'd0);
                    end else begin
                        check($sformatf("sb_order_u%0d", u), 64'(e), 64'(sb_mem[u][sb_rd[u] % 64]));
                        sb_rd[u]++;
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (k_pre) begin
                    sb_rd[i] = sb_wr[i];
                end else if (v_pre[i] && r_pre[i] && (d_pre[i].tag != NULL_TAG)) begin
                    sb_mem[i][sb_wr[i] % 64] = d_pre[i];
                    sb_wr[i]++;
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (v_pre[i] && r_pre[i]) pcnt[i]++;
        end
        if (sb_en) drive_data();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        kill          = 1'b0;
        sb_en         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            pcnt[i] = 0; gcnt[i] = 0; sb_wr[i] = 0; sb_rd[i] = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.cdb_valid), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'hF);
        check("rst_cdb",   64'(|bus.cdb), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_valid", 64'(bus.cdb_valid), 64'd0);
            check("idle_ready", 64'(bus.req_ready), 64'hF);
            check("idle_cdb",   64'(|bus.cdb), 64'd0);
        end

        // single request from unit 2
        bus.req_valid = 4'b0100;
        bus.req_data[2*CDB_W +: CDB_W] = cdb_pack(6'd5, 32'hDEADBEEF);
        tick();
        bus.req_valid = '0;
        check("single_latency", 64'(bus.cdb_valid), 64'd0);
        check("single_ready",   64'(bus.req_ready), 64'hF);
        tick();
        check("single_valid", 64'(bus.cdb_valid), 64'b001);
        check("single_slot0", 64'(slot(0)), 64'(cdb_pack(6'd5, 32'hDEADBEEF)));
        tick();
        check("single_clear", 64'(bus.cdb_valid), 64'd0);

        // kill while idle returns rr_ptr to 0
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_idle_valid", 64'(bus.cdb_valid), 64'd0);

        // oversubscription: all four units push every cycle
        for (int i = 0; i < NR; i++) pcnt[i] = 0;
        sb_en = 1'b1;
        drive_data();
        bus.req_valid = 4'hF;
`ifdef CDB_ARBITER_PERF_EN
        check("perf_start_grant",    64'(perf_grant_cnt), 64'd0);
        check("perf_start_conflict", 64'(perf_conflict_cnt), 64'd0);
`endif
        for (int c = 1; c <= 21; c++) begin
            tick();
            case (c)
                1: check("os_c1_valid", 64'(bus.cdb_valid), 64'd0);
                2: begin
                    check("os_c2_valid", 64'(bus.cdb_valid), 64'b111);
                    check("os_c2_ready", 64'(bus.req_ready), 64'b0111);
                    check("os_c2_s0", 64'(slot(0)), 64'(exp_word(0, 0)));
                    check("os_c2_s1", 64'(slot(1)), 64'(exp_word(1, 0)));
                    check("os_c2_s2", 64'(slot(2)), 64'(exp_word(2, 0)));
                end
                3: begin
                    check("os_c3_ready", 64'(bus.req_ready), 64'b1011);
                    check("os_c3_s0", 64'(slot(0)), 64'(exp_word(3, 0)));
                    check("os_c3_s1", 64'(slot(1)), 64'(exp_word(0, 1)));
                    check("os_c3_s2", 64'(slot(2)), 64'(exp_word(1, 1)));
                end
                4: begin
                    check("os_c4_ready", 64'(bus.req_ready), 64'b1101);
                    check("os_c4_s0", 64'(slot(0)), 64'(exp_word(2, 1)));
                    check("os_c4_s1", 64'(slot(1)), 64'(exp_word(3, 1)));
                    check("os_c4_s2", 64'(slot(2)), 64'(exp_word(0, 2)));
                end
                5: begin
                    check("os_c5_ready", 64'(bus.req_ready), 64'b1110);
                    check("os_c5_s0", 64'(slot(0)), 64'(exp_word(1, 2)));
                    check("os_c5_s1", 64'(slot(1)), 64'(exp_word(2, 2)));
                    check("os_c5_s2", 64'(slot(2)), 64'(exp_word(3, 2)));
                end
                default: check("os_full_valid", 64'(bus.cdb_valid), 64'b111);
            endcase
        end
        for (int u = 0; u < NR; u++) begin
            check($sformatf("fair_grants_u%0d", u), 64'(gcnt[u]), 64'd15);
        end
`ifdef CDB_ARBITER_PERF_EN
        check("perf_grant",    64'(perf_grant_cnt), 64'd60);
        check("perf_conflict", 64'(perf_conflict_cnt), 64'd20);
`endif
        bus.req_valid = '0;
        repeat (4) tick();
        for (int u = 0; u < NR; u++) begin
            check($sformatf("drain_empty_u%0d", u), 64'(sb_wr[u] - sb_rd[u]), 64'd0);
        end
        check("drain_valid", 64'(bus.cdb_valid), 64'd0);
        check("drain_ready", 64'(bus.req_ready), 64'hF);

        // kill with backlog and concurrent pushes
        bus.req_valid = 4'hF;
        tick();
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        bus.req_valid = '0;
        check("kill_valid", 64'(bus.cdb_valid), 64'd0);
        check("kill_cdb",   64'(|bus.cdb), 64'd0);
        check("kill_ready", 64'(bus.req_ready), 64'hF);
`ifdef CDB_ARBITER_PERF_EN
        check("kill_perf_grant", 64'(perf_grant_cnt), 64'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_kill_valid", 64'(bus.cdb_valid), 64'd0);
        end
        k0 = pcnt[0]; k1 = pcnt[1]; k2 = pcnt[2]; k3 = pcnt[3];
        bus.req_valid = 4'hF;
        tick();
        bus.req_valid = '0;
        tick();
        check("rr0_valid", 64'(bus.cdb_valid), 64'b111);
        check("rr0_s0", 64'(slot(0)), 64'(exp_word(0, k0)));
        check("rr0_s1", 64'(slot(1)), 64'(exp_word(1, k1)));
        check("rr0_s2", 64'(slot(2)), 64'(exp_word(2, k2)));
        tick();
        check("rr0_next_valid", 64'(bus.cdb_valid), 64'b001);
        check("rr0_next_s0", 64'(slot(0)), 64'(exp_word(3, k3)));
        tick();
        sb_en = 1'b0;

        // null tag is accepted but never broadcast
        bus.req_data[1*CDB_W +: CDB_W] = cdb_pack(6'd0, 32'h1234_5678);
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        check("tag0_ready", 64'(bus.req_ready), 64'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tag0_valid", 64'(bus.cdb_valid), 64'd0);
        end

        // asynchronous reset with entries still queued
        bus.req_data[0*CDB_W +: CDB_W] = cdb_pack(6'd7, 32'h0000_0011);
        bus.req_data[3*CDB_W +: CDB_W] = cdb_pack(6'd9, 32'h0000_0099);
        bus.req_valid = 4'b1001;
        tick();
        tick();
        bus.req_valid = '0;
        check("ares_pre_valid", 64'(bus.cdb_valid), 64'b011);
        check("ares_pre_s1", 64'(slot(1)), 64'(cdb_pack(6'd9, 32'h0000_0099)));
        #2;
        reset_n = 1'b0;
        #1;
        check("ares_valid", 64'(bus.cdb_valid), 64'd0);
        check("ares_cdb",   64'(|bus.cdb), 64'd0);
        check("ares_ready", 64'(bus.req_ready), 64'hF);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("ares_after1", 64'(bus.cdb_valid), 64'd0);
        tick();
        check("ares_after2", 64'(bus.cdb_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
